// File: rtl/rf_wb_sched.sv
// Write-port scheduler for the single-write-port register file: arbitrates pipeline
// writeback against buffered long-latency results and tracks their busy destinations.
module rf_wb_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic                 iss_long,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        iss_rs1,
  input  logic [AW-1:0]        iss_rs2,
  input  logic                 iss_use_rs1,
  input  logic                 iss_use_rs2,
  output logic                 iss_stall,
  input  logic                 p_we,
  input  logic [AW-1:0]        p_wa,
  input  logic [DW-1:0]        p_wd,
  output logic                 wb_hold,
  input  logic                 l_valid,
  input  logic [AW-1:0]        l_wa,
  input  logic [DW-1:0]        l_wd,
  output logic                 l_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic [(1<<AW)-1:0]   sb_busy
);

  localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    NREG     = 1 << AW;
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0]   fifo_wa_q [DEPTH];
  logic [DW-1:0]   fifo_wd_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            full, empty, push, pop, long_acc;
  logic [AW-1:0]   head_wa, sel_wa;
  logic [DW-1:0]   head_wd, sel_wd;
  logic            sel_we;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign l_ready = !full;
  assign wb_hold = full;
  assign push    = l_valid & !full;
  assign pop     = !p_we & !empty;
  assign head_wa = fifo_wa_q[rd_ptr_q];
  assign head_wd = fifo_wd_q[rd_ptr_q];
  assign sb_busy = busy_q;

  // Address 0 must never reach the regfile port, not even as a disabled write:
  // the regfile forwards wd3 on an address match regardless of we3.
  always_comb begin
    sel_we = p_we | !empty;
    sel_wa = p_we ? p_wa : head_wa;
    sel_wd = p_we ? p_wd : head_wd;
    rf_we  = 1'b0;
    rf_wa  = '0;
    rf_wd  = '0;
    if (sel_we && (sel_wa != '0)) begin
      rf_we = 1'b1;
      rf_wa = sel_wa;
      rf_wd = sel_wd;
    end
  end

  always_comb begin
    iss_stall = iss_valid & ((iss_use_rs1 & busy_q[iss_rs1]) |
                             (iss_use_rs2 & busy_q[iss_rs2]) |
                             ((iss_rd != '0) & busy_q[iss_rd]));
    long_acc  = iss_valid & iss_long & !iss_stall & (iss_rd != '0);
  end

  always_comb begin
    busy_d = busy_q;
    if (pop && (head_wa != '0)) busy_d[head_wa] = 1'b0;
    if (long_acc)               busy_d[iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_wa_q[i] <= '0;
        fifo_wd_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_wa_q[wr_ptr_q] <= l_wa;
        fifo_wd_q[wr_ptr_q] <= l_wd;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

`ifndef SYNTHESIS
  // Pipeline writing while the FIFO is full starves the drain path.
  a_no_we_on_hold: assert property (@(posedge clk) disable iff (!rst_n) !(p_we && wb_hold))
    else $error("p_we asserted while wb_hold");
`endif

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler and scoreboard in front of the single-write-port register file.
- Shares the one write port between two sources: the in-order pipeline writeback and a multi-cycle unit (mul/div/load-miss).
- Long-latency results are buffered in a small FIFO and drained when the pipeline is not writing.
- A 32-entry busy scoreboard stalls issue on RAW/WAW hazards against outstanding long-latency destinations.

Parameters:
- DEPTH, 4, long-result FIFO entries (power of 2, >=2)
- DW, 32, data width
- AW, 5, register address width (32 regs)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decode presents an instruction this cycle
- iss_long  in  1  instruction's result comes from the long unit
- iss_rd  in  AW  destination register
- iss_rs1, iss_rs2  in  AW  source registers
- iss_use_rs1, iss_use_rs2  in  1  source actually read
- iss_stall  out  1  decode must hold (combinational)
- p_we  in  1  pipeline writeback valid
- p_wa  in  AW  pipeline writeback address
- p_wd  in  DW  pipeline writeback data
- wb_hold  out  1  pipeline must not assert p_we this cycle
- l_valid  in  1  long unit result valid
- l_wa  in  AW  long result address
- l_wd  in  DW  long result data
- l_ready  out  1  FIFO accepts long result
- rf_we  out  1  regfile write enable
- rf_wa  out  AW  regfile write address
- rf_wd  out  DW  regfile write data
- sb_busy  out  32  scoreboard busy vector (debug)

Behaviour:
- Reset (async, rst_n=0): FIFO empty, count=0, rd/wr pointers 0, sb_busy=0. Outputs: rf_we=0, rf_wa=0, rf_wd=0, l_ready=1, wb_hold=0, iss_stall=0. Reset mid-operation discards all buffered results and busy bits.
- FIFO:
  - Push when l_valid & l_ready.
  - l_ready = (count != DEPTH).
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged, including when full: l_ready stays 0 when full, even if a pop occurs that cycle.
- Write-port arbitration (combinational, zero latency):
  - p_we=1: rf_we=1, rf_wa=p_wa, rf_wd=p_wd; no pop.
  - Else if FIFO not empty: rf_we=1, rf_wa/rf_wd = FIFO head; pop.
  - Else: rf_we=0.
  - Whenever rf_we=0 or the selected address is 0: rf_we=0, rf_wa=0, rf_wd=0. This is mandatory because the regfile forwards wd3 whenever wa3 matches a read address, regardless of we3.
  - A FIFO-head entry with address 0 is popped silently.
- wb_hold = (count == DEPTH). p_we asserted while wb_hold=1 is a protocol violation: the pipeline write still wins and the FIFO does not drain. Flag it with an assertion in simulation.
- Scoreboard:
  - Set busy[iss_rd] on an accepted long issue: iss_valid & iss_long & !iss_stall & iss_rd!=0.
  - Clear busy[a] in the cycle the FIFO head with address a is written to the regfile.
  - Set and clear of the same bit in one cycle: set wins. This is unreachable given the WAW stall, but must still be defined as above.
  - busy[0] is always 0.
- iss_stall = iss_valid & ( (iss_use_rs1 & busy[iss_rs1]) | (iss_use_rs2 & busy[iss_rs2]) | (iss_rd!=0 & busy[iss_rd]) ).
  - This covers RAW and WAW hazards for both long and pipeline issues.
  - A busy bit cleared this cycle still stalls this cycle; it releases next cycle, when the regfile bypass or array supplies the value.
- The long unit may return results out of issue order; each FIFO entry carries its own address.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with 2 FIFO entries -> next cycle count=0, sb_busy=0, rf_we=0, rf_wa=0, rf_wd=0, l_ready=1.
- Priority: p_we=1 (x5, 0x11) and FIFO head (x7, 0x22) in the same cycle -> x5 written, then x7 the next idle cycle; busy[7] clears on that cycle.
- Full/hold: 4 long results pushed while p_we stays 1 -> l_ready=0 and wb_hold=1 with count=4; drop p_we -> one pop, wb_hold=0 next cycle.
- RAW stall: long issue rd=x3 accepted, then an issue using rs1=x3 -> iss_stall=1 until the cycle after the x3 result is written; iss_stall=0 with rs1=x4.
- WAW and x0: issue rd=x3 while busy[3] -> stall. Long issue rd=x0 -> no busy bit set, and its FIFO entry is popped with rf_we=0, rf_wa=0.
- Wrap/simultaneous: 10 back-to-back push/pop pairs with p_we=0 -> count stays 1, pointers wrap, results exit in push order.
